// File: rtl/srrc_impulse_seq_pkg.sv
// Shared state encodings and default constants for the SRRC impulse-response sequencer.
package srrc_impulse_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } seq_state_e;

    localparam int DW_DEFAULT = 18;

    // 1s17 amplitude shared with the symbol mapper's +2 level
    localparam logic signed [17:0] SYMBOL_P2 = 18'sh0C000;

endpackage

// File: rtl/srrc_cap_ram.sv
// Capture buffer: one write port, one registered read port, old data returned on collision.
module srrc_cap_ram #(
    parameter int DEPTH = 128,
    parameter int DW    = 18
) (
    input  logic                     sys_clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DW-1:0]            rd_data
);

    logic [DW-1:0] mem_r [DEPTH];

    // Write port; array left unreset so it maps onto block RAM
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read of the pre-edge contents
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= {DW{1'b0}};
        end else begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/srrc_impulse_seq.sv
// Impulse injection and response capture sequencer for SRRC filter characterisation.
// Build option IMP_SYM_ALIGN_EN defers injection to the next symbol-aligned sample.
module srrc_impulse_seq
    import srrc_impulse_seq_pkg::*;
#(
    parameter int                    IMP_DELAY = 29,
    parameter int                    CAP_LEN   = 128,
    parameter int                    DW        = DW_DEFAULT,
    parameter logic signed [DW-1:0]  IMP_VALUE = DW'(SYMBOL_P2)
) (
    input  logic                       sys_clk,
    input  logic                       reset_n,
    input  logic                       sam_clk_en,
    input  logic                       sym_clk_en,
    input  logic                       start,
    input  logic                       abort,
    input  logic [DW-1:0]              response,
    output logic [DW-1:0]              stimulus,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(CAP_LEN):0]   cap_count,
    input  logic [$clog2(CAP_LEN)-1:0] rd_addr,
    output logic [DW-1:0]              rd_data
);

    localparam int AW = $clog2(CAP_LEN);
    localparam int CW = AW + 1;

    localparam logic [8:0]    DELAY_LAST = 9'(IMP_DELAY - 1);
    localparam logic [AW-1:0] PTR_LAST   = AW'(CAP_LEN - 1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(CAP_LEN);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);

    seq_state_e    state_r, state_s;
    logic [DW-1:0] stimulus_r, stimulus_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic [8:0]    delay_cnt_r, delay_cnt_s;
    logic [AW-1:0] wr_ptr_r, wr_ptr_s;
    logic [CW-1:0] cap_count_r, cap_count_s;
    logic          wr_en_s;
    logic          inject_s;

`ifdef IMP_SYM_ALIGN_EN
    assign inject_s = (delay_cnt_r == DELAY_LAST) && sym_clk_en;
`else
    logic unused_sym_s;
    assign inject_s     = (delay_cnt_r == DELAY_LAST);
    assign unused_sym_s = sym_clk_en;
`endif

    // Next-state logic; abort overrides every other action in the cycle
    always_comb begin
        state_s     = state_r;
        stimulus_s  = stimulus_r;
        busy_s      = busy_r;
        done_s      = done_r;
        delay_cnt_s = delay_cnt_r;
        wr_ptr_s    = wr_ptr_r;
        cap_count_s = cap_count_r;
        wr_en_s     = 1'b0;
        if (abort) begin
            state_s    = IDLE;
            stimulus_s = {DW{1'b0}};
            busy_s     = 1'b0;
            done_s     = 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_s     = ARM;
                        busy_s      = 1'b1;
                        done_s      = 1'b0;
                        delay_cnt_s = 9'd0;
                        cap_count_s = {CW{1'b0}};
                    end else begin
                        state_s = state_r;
                    end
                end
                ARM: begin
                    if (sam_clk_en) begin
                        // counter parks at its last value so it never wraps while waiting
                        if (delay_cnt_r != DELAY_LAST) begin
                            delay_cnt_s = delay_cnt_r + 9'd1;
                        end else begin
                            delay_cnt_s = delay_cnt_r;
                        end
                        if (inject_s) begin
                            stimulus_s = IMP_VALUE;
                            wr_ptr_s   = {AW{1'b0}};
                            state_s    = CAPTURE;
                        end else begin
                            state_s = ARM;
                        end
                    end else begin
                        state_s = ARM;
                    end
                end
                CAPTURE: begin
                    if (sam_clk_en) begin
                        stimulus_s = {DW{1'b0}};
                        wr_en_s    = 1'b1;
                        wr_ptr_s   = wr_ptr_r + PTR_ONE;
                        if (cap_count_r != CNT_FULL) begin
                            cap_count_s = cap_count_r + CNT_ONE;
                        end else begin
                            cap_count_s = cap_count_r;
                        end
                        if (wr_ptr_r == PTR_LAST) begin
                            state_s = DONE;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                        end else begin
                            state_s = CAPTURE;
                        end
                    end else begin
                        state_s = CAPTURE;
                    end
                end
                default: begin
                    state_s    = IDLE;
                    stimulus_s = {DW{1'b0}};
                    busy_s     = 1'b0;
                    done_s     = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and output registers
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            stimulus_r  <= {DW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            delay_cnt_r <= 9'd0;
            wr_ptr_r    <= {AW{1'b0}};
            cap_count_r <= {CW{1'b0}};
        end else begin
            state_r     <= state_s;
            stimulus_r  <= stimulus_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            delay_cnt_r <= delay_cnt_s;
            wr_ptr_r    <= wr_ptr_s;
            cap_count_r <= cap_count_s;
        end
    end

    assign stimulus  = stimulus_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cap_count = cap_count_r;

    srrc_cap_ram #(
        .DEPTH (CAP_LEN),
        .DW    (DW)
    ) u_cap_ram (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_r),
        .wr_data (response),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_srrc_impulse_seq.sv
// Directed bench for srrc_impulse_seq; sam_clk_en every 4th sys_clk, sym_clk_en every 16th.
module tb_srrc_impulse_seq;

    localparam int DW = 18;
    localparam int AW = 7;
    localparam logic [DW-1:0] IMP = 18'h0C000;

    logic          sys_clk    = 1'b0;
    logic          reset_n    = 1'b0;
    logic          sam_clk_en = 1'b0;
    logic          sym_clk_en = 1'b0;
    logic          start      = 1'b0;
    logic          abort      = 1'b0;
    logic [DW-1:0] response   = 18'd0;
    logic [AW-1:0] rd_addr    = 7'd0;
    logic [DW-1:0] stimulus;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [AW:0]   cap_count;

    int total = 0;
    int bad = 0;
    int phase = 0;
    int sam_edges = 0;
    int resp_base = 0;
    int exp_inj = 114;

    srrc_impulse_seq dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .sam_clk_en (sam_clk_en),
        .sym_clk_en (sym_clk_en),
        .start      (start),
        .abort      (abort),
        .response   (response),
        .stimulus   (stimulus),
        .busy       (busy),
        .done       (done),
        .cap_count  (cap_count),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    always #5 sys_clk = ~sys_clk;

    // Strobes and response source; response equals the capture sample index during a run
    initial begin
        forever begin
            @(negedge sys_clk);
            if (sam_clk_en) sam_edges = sam_edges + 1;
            phase = (phase + 1) % 16;
            sam_clk_en = (phase % 4 == 3);
            sym_clk_en = (phase == 15);
            response = DW'(sam_edges - resp_base);
        end
    end

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    // Issues a one-cycle start on a non-sample edge; relative cycle c=0 is the start edge
    task automatic start_run;
        int s;
        int p0;
        while (phase % 4 != 0) tick();
        s = sam_edges;
        p0 = (phase + 1) % 16;
        exp_inj = 114;
`ifdef IMP_SYM_ALIGN_EN
        while ((p0 + exp_inj) % 16 != 15) exp_inj = exp_inj + 4;
`endif
        resp_base = s + 29 + (exp_inj - 114) / 4;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_capture(input int poke_c, output int first_hi, output int hi_cycles,
                               output int fall_c, output logic [DW-1:0] hi_val);
        first_hi = -1;
        hi_cycles = 0;
        fall_c = -1;
        hi_val = 18'd0;
        start_run();
        for (int c = 1; c <= 1000 && fall_c < 0; c++) begin
            start = (c == poke_c);
            tick();
            if (stimulus != 18'd0) begin
                hi_cycles++;
                if (first_hi < 0) begin
                    first_hi = c;
                    hi_val = stimulus;
                end
            end
            if (!busy) fall_c = c;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) tick();
        total++;
        if ({stimulus, busy, done, cap_count, rd_data} !== 45'd0) begin
            bad++;
            $display("FAIL reset_state: got stim=%h busy=%b done=%b cnt=%0d rd=%h want all zero",
                     stimulus, busy, done, cap_count, rd_data);
        end
        @(negedge sys_clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic(input string tag, input int poke_c);
        int fh, hc, fc;
        logic [DW-1:0] hv;
        run_capture(poke_c, fh, hc, fc, hv);
        total++;
        if (fh != exp_inj) begin
            bad++; $display("FAIL %s_inject_cycle: got %0d want %0d", tag, fh, exp_inj);
        end
        total++;
        if (hv !== IMP) begin
            bad++; $display("FAIL %s_impulse_value: got %h want %h", tag, hv, IMP);
        end
        total++;
        if (hc != 4) begin
            bad++; $display("FAIL %s_impulse_width: got %0d want 4", tag, hc);
        end
        total++;
        if (fc != exp_inj + 512) begin
            bad++; $display("FAIL %s_complete_cycle: got %0d want %0d", tag, fc, exp_inj + 512);
        end
        total++;
        if (done !== 1'b1 || cap_count !== 8'd128) begin
            bad++; $display("FAIL %s_done: got done=%b cnt=%0d want done=1 cnt=128", tag, done, cap_count);
        end
    endtask

    task automatic test_buffer;
        for (int a = 0; a < 128; a++) begin
            rd_addr = AW'(a);
            if (a > 0) begin
                total++;
                if (rd_data !== DW'(a - 1)) begin
                    bad++; $display("FAIL buffer_latency[%0d]: got %h want %h", a, rd_data, DW'(a - 1));
                end
            end
            tick();
            total++;
            if (rd_data !== DW'(a)) begin
                bad++; $display("FAIL buffer_data[%0d]: got %h want %h", a, rd_data, DW'(a));
            end
        end
    endtask

    task automatic test_abort;
        // abort while the impulse is on the line clears it at once
        start_run();
        for (int c = 1; c <= exp_inj + 1; c++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (stimulus !== 18'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_impulse: got stim=%h busy=%b want 0 0", stimulus, busy);
        end
        // abort after 50 captured samples
        start_run();
        for (int c = 1; c <= exp_inj + 201; c++) tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        total++;
        if ({stimulus, busy, done} !== 20'd0 || cap_count !== 8'd50) begin
            bad++; $display("FAIL abort_capture: got stim=%h busy=%b done=%b cnt=%0d want 0 0 0 50",
                            stimulus, busy, done, cap_count);
        end
        repeat (20) tick();
        rd_addr = 7'd49;
        tick();
        total++;
        if (busy !== 1'b0 || cap_count !== 8'd50 || rd_data !== 18'd49) begin
            bad++; $display("FAIL abort_hold: got busy=%b cnt=%0d rd=%h want 0 50 00031", busy, cap_count, rd_data);
        end
        test_basic("after_abort", -1);
    endtask

    task automatic test_back_to_back;
        int fell;
        fell = 0;
        start_run();
        start = 1'b1;
        for (int c = 1; c <= 1000 && fell == 0; c++) begin
            tick();
            if (!busy) fell = 1;
        end
        total++;
        if (fell != 1 || done !== 1'b1) begin
            bad++; $display("FAIL b2b_complete: got fell=%0d done=%b want 1 1", fell, done);
        end
        tick();
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || cap_count !== 8'd0) begin
            bad++; $display("FAIL b2b_restart: got busy=%b done=%b cnt=%0d want 1 0 0", busy, done, cap_count);
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_async_reset;
        int stray;
        stray = 0;
        rd_addr = 7'd5;
        start_run();
        repeat (50) tick();
        total++;
        if (busy !== 1'b1 || rd_data !== 18'd5) begin
            bad++; $display("FAIL areset_pre: got busy=%b rd=%h want 1 00005", busy, rd_data);
        end
        #1;
        reset_n = 1'b0;
        #1;
        total++;
        if ({stimulus, busy, done, cap_count, rd_data} !== 45'd0) begin
            bad++; $display("FAIL areset_async: got stim=%h busy=%b done=%b cnt=%0d rd=%h want all zero",
                            stimulus, busy, done, cap_count, rd_data);
        end
        @(negedge sys_clk);
        reset_n = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (stimulus != 18'd0 || busy || done) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++; $display("FAIL areset_idle: got %0d active cycles want 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_basic("basic", -1);
        test_buffer();
        test_abort();
        test_basic("start_busy", exp_inj + 44);
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
